// File: rtl/fp_pkg.sv
// Shared single-precision constants and types for the fp datapath blocks
// (fdiv, fmul).
package fp_pkg;

  localparam int BIAS  = 127;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  localparam logic [31:0] QNAN    = 32'h7fc00000;
  localparam logic [31:0] POS_INF = 32'h7f800000;

  // Sequencing states shared by the multi-cycle fp operators
  typedef enum logic [2:0] {
    IDLE,
    PREP,
    DIV,
    NORM,
    DONE
  } state_t;

  // Operand classification produced by fp_unpack
  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_DENORM,
    CLS_NORMAL,
    CLS_INF,
    CLS_NAN
  } fp_class_t;

  // Result override selected when operands are not both finite nonzero
  typedef enum logic [2:0] {
    SP_NONE,
    SP_NAN,
    SP_INF,
    SP_ZERO,
    SP_DBZ
  } special_t;

  // Packed result word plus its exception flags
  typedef struct packed {
    logic [31:0] word;
    logic        ovf;
    logic        unf;
    logic        dbz;
  } fp_res_t;

endpackage

// File: rtl/fp_unpack.sv
// Classifies one IEEE-754 single magnitude and returns a 24-bit mantissa in
// [1,2) with its effective biased exponent; denormals are left-normalized so
// the divider never sees a leading zero.
module fp_unpack
  import fp_pkg::*;
(
  input  logic [30:0]        mag,
  output fp_class_t          cls,
  output logic [MAN_W:0]     mant,
  output logic signed [9:0]  bexp
);

  logic [EXP_W-1:0] e;
  logic [MAN_W-1:0] f;
  logic [4:0]       lz;

  assign e = mag[30:23];
  assign f = mag[22:0];

  // Shift that brings the highest set fraction bit up to the hidden-bit slot
  always_comb begin
    lz = '0;
    for (int i = 0; i < MAN_W; i++) begin
      if (f[i]) lz = 5'(MAN_W - i);
    end
  end

  // Class, normalized mantissa and effective exponent
  always_comb begin
    cls  = CLS_NORMAL;
    mant = {1'b1, f};
    bexp = signed'({2'b00, e});
    if (e == '0) begin
      if (f == '0) begin
        cls = CLS_ZERO;
      end else begin
        cls  = CLS_DENORM;
        mant = {1'b0, f} << lz;
        bexp = 10'sd1 - signed'({5'b00000, lz});
      end
    end else if (e == '1) begin
      cls = (f == '0) ? CLS_INF : CLS_NAN;
    end
  end

endmodule

// File: rtl/fdiv.sv
// Multi-cycle IEEE-754 single-precision divider. Restoring division, one
// quotient bit per cycle, truncating result, flush-to-zero on underflow.
// Every operand class takes the same number of cycles.
module fdiv
  import fp_pkg::*;
#(
  parameter int ITER = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic [31:0] out,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic        underflow,
  output logic        div_by_zero
);

  localparam int CNT_W = $clog2(ITER + 1);
  localparam int REM_W = MAN_W + 3;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;

  logic [31:0]       a_p0;
  logic [31:0]       b_p0;

  fp_class_t         cls_a;
  fp_class_t         cls_b;
  logic [MAN_W:0]    man_a;
  logic [MAN_W:0]    man_b;
  logic signed [9:0] ex_a;
  logic signed [9:0] ex_b;
  special_t          sp_cls;
  logic signed [9:0] ex_diff;

  logic [MAN_W:0]    divisor_p1;
  logic [REM_W-1:0]  rem_p1;
  logic [ITER-1:0]   quo_p1;
  logic signed [9:0] ex_p1;
  logic              sign_p1;
  special_t          sp_p1;

  logic [REM_W-1:0]  rem_sub;
  logic              qbit;

  logic [MAN_W-1:0]  frac_n;
  logic signed [9:0] ex_n;
  fp_res_t           res;

  // Range-limit a finite result: saturate to infinity or flush to zero
  function automatic fp_res_t saturate(input logic s,
                                       input logic signed [9:0] e,
                                       input logic [MAN_W-1:0] f);
    fp_res_t r;
    r = '0;
    if (e >= 10'sd255) begin
      r.word = {s, POS_INF[30:0]};
      r.ovf  = 1'b1;
    end else if (e <= 10'sd0) begin
      r.word = {s, 31'b0};
      r.unf  = 1'b1;
    end else begin
      r.word = {s, e[EXP_W-1:0], f};
    end
    return r;
  endfunction

  // Fixed result for operand combinations that bypass the quotient
  function automatic fp_res_t special_res(input special_t sp, input logic s);
    fp_res_t r;
    r = '0;
    case (sp)
      SP_NAN:  r.word = QNAN;
      SP_INF:  r.word = {s, POS_INF[30:0]};
      SP_DBZ:  begin
        r.word = {s, POS_INF[30:0]};
        r.dbz  = 1'b1;
      end
      SP_ZERO: r.word = {s, 31'b0};
      default: r.word = '0;
    endcase
    return r;
  endfunction

  fp_unpack u_unpack_a (
    .mag  (a_p0[30:0]),
    .cls  (cls_a),
    .mant (man_a),
    .bexp (ex_a)
  );

  fp_unpack u_unpack_b (
    .mag  (b_p0[30:0]),
    .cls  (cls_b),
    .mant (man_b),
    .bexp (ex_b)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; start is only looked at in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = PREP;
      PREP:    state_nxt = DIV;
      DIV:     if (cnt == CNT_W'(ITER - 1)) state_nxt = NORM;
      NORM:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from the state register
  always_comb begin
    busy = (state == PREP) || (state == DIV) || (state == NORM);
    done = (state == DONE);
  end

  // Quotient bit counter for the DIV phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (state == PREP)  cnt <= '0;
    else if (state == DIV)   cnt <= cnt + 1'b1;
  end

  // Stage p0: operand capture on the edge that accepts start
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      a_p0 <= in1;
      b_p0 <= in2;
    end
  end

  // Special-case selection and unbiased exponent difference
  always_comb begin
    sp_cls = SP_NONE;
    if (cls_a == CLS_NAN || cls_b == CLS_NAN)        sp_cls = SP_NAN;
    else if (cls_a == CLS_ZERO && cls_b == CLS_ZERO) sp_cls = SP_NAN;
    else if (cls_a == CLS_INF && cls_b == CLS_INF)   sp_cls = SP_NAN;
    else if (cls_a == CLS_INF)                       sp_cls = SP_INF;
    else if (cls_b == CLS_INF)                       sp_cls = SP_ZERO;
    else if (cls_a == CLS_ZERO)                      sp_cls = SP_ZERO;
    else if (cls_b == CLS_ZERO)                      sp_cls = SP_DBZ;
    ex_diff = ex_a - ex_b + signed'(10'(BIAS));
  end

  // Restoring-division trial subtract
  always_comb begin
    qbit    = (rem_p1 >= {2'b00, divisor_p1});
    rem_sub = rem_p1 - {2'b00, divisor_p1};
  end

  // Stage p1: PREP loads the divider, DIV shifts in one quotient bit per cycle
  always_ff @(posedge clk) begin
    if (state == PREP) begin
      divisor_p1 <= man_b;
      rem_p1     <= {2'b00, man_a};
      quo_p1     <= '0;
      ex_p1      <= ex_diff;
      sign_p1    <= a_p0[31] ^ b_p0[31];
      sp_p1      <= sp_cls;
    end else if (state == DIV) begin
      quo_p1 <= {quo_p1[ITER-2:0], qbit};
      rem_p1 <= (qbit ? rem_sub : rem_p1) << 1;
    end
  end

  // Normalize quotient (ratio lies in (0.5,2)) and pick the final word
  always_comb begin
    if (quo_p1[ITER-1]) begin
      frac_n = quo_p1[ITER-2 -: MAN_W];
      ex_n   = ex_p1;
    end else begin
      frac_n = quo_p1[ITER-3 -: MAN_W];
      ex_n   = ex_p1 - 10'sd1;
    end
    res = (sp_p1 == SP_NONE) ? saturate(sign_p1, ex_n, frac_n)
                             : special_res(sp_p1, sign_p1);
  end

  // Stage p2: result and flags registered on the edge that enters DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out         <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (state == NORM) begin
      out         <= res.word;
      overflow    <= res.ovf;
      underflow   <= res.unf;
      div_by_zero <= res.dbz;
    end
  end

endmodule

// File: tb/tb_fdiv.sv
// Scenario bench for fdiv: expected results queued at launch, popped and
// compared when done pulses.
module tb_fdiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic [31:0] out;
  logic        busy;
  logic        done;
  logic        overflow;
  logic        underflow;
  logic        div_by_zero;

  fdiv #(.ITER(25)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .in1         (in1),
    .in2         (in2),
    .out         (out),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .underflow   (underflow),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [2:0]  fl;   // {overflow, underflow, div_by_zero}
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  logic [31:0] na [7] = '{32'h40c00000, 32'h3f800000, 32'h007fffff, 32'h7f7fffff,
                          32'h00800000, 32'hc0c00000, 32'h3f800000};
  logic [31:0] nb [7] = '{32'h40000000, 32'h40400000, 32'h3f000000, 32'h00800000,
                          32'h7f7fffff, 32'h40000000, 32'h3f800000};
  logic [31:0] nq [7] = '{32'h40400000, 32'h3eaaaaaa, 32'h00fffffe, 32'h7f800000,
                          32'h00000000, 32'hc0400000, 32'h3f800000};
  logic [2:0]  nf [7] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b010, 3'b000, 3'b000};

  logic [31:0] sa [8] = '{32'h3f800000, 32'h00000000, 32'h7f800000, 32'h3f800000,
                          32'h7f800000, 32'h40400000, 32'h00000000, 32'h7fc00001};
  logic [31:0] sbv[8] = '{32'h00000000, 32'h00000000, 32'h7f800000, 32'h80000000,
                          32'h40400000, 32'hff800000, 32'h40400000, 32'h3f800000};
  logic [31:0] sq [8] = '{32'h7f800000, 32'h7fc00000, 32'h7fc00000, 32'hff800000,
                          32'h7f800000, 32'h80000000, 32'h00000000, 32'h7fc00000};
  logic [2:0]  sf [8] = '{3'b001, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000};

  // Drive one request across the capturing edge, then scramble the inputs
  task automatic launch(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q, input logic [2:0] fl);
    exp_t e;
    e.q  = q;
    e.fl = fl;
    sb.push_back(e);
    in1   = a;
    in2   = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    in1   = $urandom;
    in2   = $urandom;
  endtask

  // Step edges until done, bounded; lat is the edge number done was seen at
  task automatic wait_done(input int lat0, output bit ok, output int lat,
                           output bit busy_bad);
    lat      = lat0;
    ok       = 1'b0;
    busy_bad = 1'b0;
    while (!ok && lat < lat0 + 60) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) begin
        ok = 1'b1;
        if (busy) busy_bad = 1'b1;
      end else if (!busy) begin
        busy_bad = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    tests++; if (out !== 32'h0) begin fails++; $display("FAIL reset_out: got %h want 00000000", out); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    tests++; if ({overflow, underflow, div_by_zero} !== 3'b000) begin
      fails++; $display("FAIL reset_flags: got %b want 000", {overflow, underflow, div_by_zero});
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_normal();
    bit ok, bb;
    int lat;
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      launch(na[i], nb[i], nq[i], nf[i]);
      wait_done(1, ok, lat, bb);
      e = sb.pop_front();
      tests++; if (!ok || lat != 28) begin fails++; $display("FAIL normal[%0d]_latency: got %0d want 28", i, lat); end
      tests++; if (out !== e.q) begin fails++; $display("FAIL normal[%0d]_out: got %h want %h", i, out, e.q); end
      tests++; if ({overflow, underflow, div_by_zero} !== e.fl) begin
        fails++; $display("FAIL normal[%0d]_flags: got %b want %b", i, {overflow, underflow, div_by_zero}, e.fl);
      end
      tests++; if (bb) begin fails++; $display("FAIL normal[%0d]_busy: got irregular busy want high until DONE", i); end
      @(posedge clk);
      #1;
      tests++; if (done !== 1'b0 || out !== e.q) begin
        fails++; $display("FAIL normal[%0d]_hold: got done=%b out=%h want done=0 out=%h", i, done, out, e.q);
      end
    end
  endtask

  task automatic test_special();
    bit ok, bb;
    int lat;
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      launch(sa[i], sbv[i], sq[i], sf[i]);
      wait_done(1, ok, lat, bb);
      e = sb.pop_front();
      tests++; if (!ok || lat != 28) begin fails++; $display("FAIL special[%0d]_latency: got %0d want 28", i, lat); end
      tests++; if (out !== e.q) begin fails++; $display("FAIL special[%0d]_out: got %h want %h", i, out, e.q); end
      tests++; if ({overflow, underflow, div_by_zero} !== e.fl) begin
        fails++; $display("FAIL special[%0d]_flags: got %b want %b", i, {overflow, underflow, div_by_zero}, e.fl);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_ignore_start();
    bit ok, bb;
    int lat, dn;
    exp_t e;
    launch(32'h40c00000, 32'h40000000, 32'h40400000, 3'b000);
    repeat (8) @(posedge clk);
    #1;
    start = 1'b1;
    in1   = 32'h3f800000;
    in2   = 32'h40400000;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(10, ok, lat, bb);
    e = sb.pop_front();
    tests++; if (!ok || lat != 28) begin fails++; $display("FAIL ignore_latency: got %0d want 28", lat); end
    tests++; if (out !== e.q) begin fails++; $display("FAIL ignore_out: got %h want %h", out, e.q); end
    tests++; if (bb) begin fails++; $display("FAIL ignore_busy: got irregular busy want high until DONE"); end
    dn = 0;
    repeat (35) begin
      @(posedge clk);
      #1;
      if (done) dn++;
    end
    tests++; if (dn != 0) begin fails++; $display("FAIL ignore_extra_done: got %0d pulses want 0", dn); end
  endtask

  task automatic test_back_to_back();
    bit ok, bb;
    int lat;
    exp_t e, e2;
    e.q  = 32'h3eaaaaaa;
    e.fl = 3'b000;
    sb.push_back(e);
    in1   = 32'h3f800000;
    in2   = 32'h40400000;
    start = 1'b1;
    @(posedge clk);
    #1;
    e2.q  = 32'hc0400000;
    e2.fl = 3'b000;
    sb.push_back(e2);
    in1 = 32'hc0c00000;
    in2 = 32'h40000000;
    wait_done(1, ok, lat, bb);
    e = sb.pop_front();
    tests++; if (!ok || lat != 28) begin fails++; $display("FAIL b2b_first_latency: got %0d want 28", lat); end
    tests++; if (out !== e.q) begin fails++; $display("FAIL b2b_first_out: got %h want %h", out, e.q); end
    @(posedge clk);
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_start_in_done: got busy=%b want 0", busy); end
    @(posedge clk);
    #1;
    start = 1'b0;
    in1   = $urandom;
    in2   = $urandom;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_held_start: got busy=%b want 1", busy); end
    wait_done(1, ok, lat, bb);
    e = sb.pop_front();
    tests++; if (!ok || lat != 28) begin fails++; $display("FAIL b2b_second_latency: got %0d want 28", lat); end
    tests++; if (out !== e.q) begin fails++; $display("FAIL b2b_second_out: got %h want %h", out, e.q); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    bit ok, bb;
    int lat;
    exp_t e;
    launch(32'h3f800000, 32'h40400000, 32'h3eaaaaaa, 3'b000);
    repeat (13) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    tests++; if (out !== 32'h0) begin fails++; $display("FAIL midreset_out: got %h want 00000000", out); end
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL midreset_status: got busy=%b done=%b want 0 0", busy, done);
    end
    tests++; if ({overflow, underflow, div_by_zero} !== 3'b000) begin
      fails++; $display("FAIL midreset_flags: got %b want 000", {overflow, underflow, div_by_zero});
    end
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    launch(32'h40c00000, 32'h40000000, 32'h40400000, 3'b000);
    wait_done(1, ok, lat, bb);
    e = sb.pop_front();
    tests++; if (!ok || lat != 28) begin fails++; $display("FAIL postreset_latency: got %0d want 28", lat); end
    tests++; if (out !== e.q) begin fails++; $display("FAIL postreset_out: got %h want %h", out, e.q); end
    tests++; if ({overflow, underflow, div_by_zero} !== e.fl) begin
      fails++; $display("FAIL postreset_flags: got %b want %b", {overflow, underflow, div_by_zero}, e.fl);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_normal();
    test_special();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fdiv.md
FDIV -- requirements
Module: fdiv

Interface
REQ-001 SHALL have parameter ITER, default 25, the number of quotient bits per divide (fixed at 25 for IEEE single precision).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request a divide; sampled only in IDLE.
REQ-005 SHALL have port in1, input, 32 bits: dividend, IEEE-754 single.
REQ-006 SHALL have port in2, input, 32 bits: divisor, IEEE-754 single.
REQ-007 SHALL have port out, output, 32 bits: quotient, registered.
REQ-008 SHALL have port busy, output, 1 bit: high while a divide is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when out and the flags become valid.
REQ-010 SHALL have ports overflow, underflow and div_by_zero, each output, 1 bit: result flags, registered with out.

Function
REQ-011 SHALL implement a state machine with states IDLE, PREP, DIV, NORM and DONE.
- IDLE->PREP when start=1.
- PREP->DIV after 1 cycle.
- DIV->NORM after ITER cycles.
- NORM->DONE after 1 cycle.
- DONE->IDLE after 1 cycle.
REQ-012 SHALL capture in1 and in2 on the edge that samples start; later input changes SHALL NOT affect the result.
REQ-013 SHALL set busy=1 from the capturing edge until the edge that enters DONE.
REQ-014 SHALL keep latency fixed for every operand class, special cases included: done=1 exactly in the DONE state, 28 edges after the capturing edge (that edge counts as edge 1), asserted for 1 cycle.
REQ-015 SHALL ignore start while busy=1 or in DONE; a start held high in IDLE begins a new divide the next cycle.
REQ-016 SHALL, in PREP, unpack both operands and normalize denormal operands to a 24-bit mantissa in [1,2) with an adjusted effective exponent.
REQ-017 SHALL compute result sign = in1[31] XOR in2[31].
REQ-018 SHALL, in DIV, generate one quotient bit per cycle by restoring division (26-bit remainder), MSB first, 25 bits total.
REQ-019 SHALL, in NORM, left-shift the quotient by 1 and decrement the exponent when quotient bit 24 = 0.
REQ-020 SHALL compute exponent = eA - eB + 127 (signed 10-bit arithmetic) and truncate the mantissa (round toward zero).
REQ-021 SHALL, when the final exponent >= 255, produce signed infinity with overflow=1.
REQ-022 SHALL, when the final exponent <= 0, flush to signed zero with underflow=1; no denormal outputs.
REQ-023 SHALL apply these special cases, classified in PREP; each SHALL still finish with the fixed latency:
- Either operand NaN, 0/0, or inf/inf: out=7fc00000.
- Finite nonzero/0: signed inf, div_by_zero=1.
- inf/finite: signed inf.
- finite/inf or 0/nonzero: signed zero.
REQ-024 SHALL hold out and the flags stable from DONE until the next divide's DONE.
REQ-025 SHALL keep flags mutually exclusive; NaN and inf-operand results raise no flag.

Reset
REQ-026 SHALL, on rst_n=0 at any time, asynchronously force state=IDLE and busy=0, done=0, out=0, overflow=0, underflow=0, div_by_zero=0.
REQ-027 SHALL discard a divide in progress at reset mid-operation; no done SHALL follow.
REQ-028 SHALL accept start on the first rising edge after rst_n deasserts.

Structure
REQ-029 SHALL take these constants from shared package fp_pkg, also used by fmul:
- BIAS=127, EXP_W=8, MAN_W=23.
- QNAN=32'h7fc00000.
- POS_INF=32'h7f800000.
- The state enum.
REQ-030 SHALL use one sub-module, fp_unpack (classify zero/denormal/normal/inf/NaN, normalize denormals), instantiated once per operand.

Verification
REQ-031 SHALL cover 40c00000 / 40000000 -> out=40400000, no flags, done 28 edges after start.
REQ-032 SHALL cover 3f800000 / 40400000 -> out=3eaaaaaa (truncated).
REQ-033 SHALL cover 007fffff / 3f000000 (denormal dividend) -> out=00fffffe.
REQ-034 SHALL cover:
- 7f7fffff / 00800000 -> out=7f800000, overflow=1.
- 00800000 / 7f7fffff -> out=00000000, underflow=1.
REQ-035 SHALL cover:
- 3f800000 / 00000000 -> out=7f800000, div_by_zero=1.
- 00000000 / 00000000 -> out=7fc00000.
- 7f800000 / 7f800000 -> out=7fc00000.
REQ-036 SHALL cover:
- start pulsed again at edge 10 of a divide -> ignored.
- rst_n low at edge 15 -> all outputs 0 and no done.
- start on the next edge after release -> normal completion.
